uart_tx_result_ctrl: RTL and testbench
======================================

Name: uart_tx_result_ctrl

Overview:
- Transmit-side controller that pairs with the UART receive controller.
- On a single-cycle `trigger`, latches the 16-bit ALU result and serialises it as bytes into the UART byte transmitter.
- Uses a `tx_start`/`tx_busy` handshake and mirrors the receive controller's hold-then-act register timing.
- Sits between the ALU result bus and the UART TX core; `done` reports completion of the whole frame.

Parameters:
- WAIT_FOR_REGISTER_DELAY, 100, cycles `tx_data` is held stable before `tx_start` is pulsed for each byte.
- BUSY_TIMEOUT, 1000, maximum cycles to wait for `tx_busy` to rise after `tx_start`; on expiry the byte is abandoned.
- LSB_FIRST, 1, 1: send result[7:0] then result[15:8]; 0: reverse order.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- trigger  input  1  single-cycle request to send `result`
- result  input  16  ALU result, sampled on the accepted `trigger`
- tx_busy  input  1  UART TX core busy; high while a byte is shifting out
- tx_start  output  1  single-cycle pulse requesting the TX core to send `tx_data`
- tx_data  output  8  byte presented to the TX core
- busy  output  1  high from accepted `trigger` until return to IDLE
- done  output  1  single-cycle pulse when the frame completes (success or timeout)
- timeout_err  output  1  sticky; set on any busy timeout, cleared by reset or the next accepted `trigger`
- LED  output  4  current state encoding, for debug

Behaviour:
- Reset (synchronous): state=IDLE, `tx_start`=0, `tx_data`=0, `busy`=0, `done`=0, `timeout_err`=0, latched result=0, byte index=0, timers=0.
- IDLE: `trigger`=1 latches `result` into an internal register, clears `timeout_err`, clears byte index, and moves to HOLD. `busy` rises the cycle after `trigger`.
- `trigger` outside IDLE is ignored. No queueing; `result` changes after latch have no effect.
- HOLD:
  - `tx_data` = current byte (index 0 = low byte if LSB_FIRST=1, else high byte).
  - Hold timer increments each cycle.
  - When the timer is >= WAIT_FOR_REGISTER_DELAY, go to START. The timer clears on leaving HOLD.
- START: `tx_start`=1 for exactly this one cycle. `tx_data` stays unchanged. Go to WAIT_HI.
- WAIT_HI:
  - Wait for `tx_busy`=1, then go to WAIT_LO.
  - A timeout counter starts at 0 on entry. If it reaches BUSY_TIMEOUT without `tx_busy`=1, set `timeout_err`=1 and go to FINISH; remaining bytes are skipped.
- WAIT_LO: wait for `tx_busy`=0 (no timeout). Then:
  - if the byte index is the last index, go to FINISH;
  - otherwise increment the index and go to HOLD.
- FINISH: `done`=1 for one cycle, `busy`=0 from the next cycle, return to IDLE.
- `tx_busy` already high on entry to WAIT_HI counts as the rise; the controller proceeds to WAIT_LO immediately.
- `tx_data` holds its last value in IDLE; it changes only on entry to HOLD.
- Nominal latency per byte: WAIT_FOR_REGISTER_DELAY + 1 (HOLD) + 1 (START) + busy-rise latency + TX byte time.
- Reset mid-frame: abort immediately. The next cycle satisfies all reset values, and no further `tx_start` is issued.
- LED: IDLE=0, HOLD=1, START=2, WAIT_HI=3, WAIT_LO=4, FINISH=5.

Optional Feature:
- Macro: UART_TX_CHECKSUM_BYTE_EN.
- Defined: a third byte is sent after the two result bytes. Its value is result[15:8] XOR result[7:0], and it uses the same HOLD/START/WAIT handshake. The last index is 2.
- Undefined: exactly two bytes per frame. The last index is 1, and no checksum logic is built.

Test Plan:
- Basic frame: `result`=16'hA53C, `trigger` pulse, TX model raises `busy` 2 cycles after start for 50 cycles. Required:
  - `tx_start` pulses twice;
  - `tx_data`=8'h3C at the first pulse, 8'hA5 at the second;
  - each pulse comes >=100 cycles after its HOLD entry;
  - `done` pulses once; `timeout_err`=0.
- Byte order: LSB_FIRST=0, `result`=16'h1234. Required: `tx_data` 8'h12 then 8'h34.
- Ignored trigger: second `trigger` with `result`=16'hFFFF during WAIT_LO of byte 0. Required: bytes sent remain 8'h3C, 8'hA5; exactly 2 `tx_start` pulses; one `done`.
- Timeout: TX model never asserts `busy`. Required:
  - after BUSY_TIMEOUT=1000 cycles in WAIT_HI, `timeout_err`=1;
  - `done` pulses and only 1 `tx_start` is seen;
  - the next `trigger` clears `timeout_err`.
- Reset mid-frame: assert `reset` in HOLD of byte 1. Required: next cycle `busy`=0, `tx_start`=0, `tx_data`=0, LED=0, and no `tx_start` afterwards until a new `trigger`.
- With UART_TX_CHECKSUM_BYTE_EN, `result`=16'hA53C. Required: bytes 8'h3C, 8'hA5, 8'h99 (A5^3C=99), and `done` after the third.

Source files
------------

// File: rtl/uart_tx_result_ctrl.sv
// uart_tx_result_ctrl
// Transmit-side companion of the UART receive controller. A single-cycle
// trigger latches the 16-bit ALU result, and the result is then sent as bytes
// through the UART TX core using a tx_start / tx_busy handshake. Each byte is
// held on tx_data for WAIT_FOR_REGISTER_DELAY cycles before tx_start is pulsed.
//
// Build option: define UART_TX_CHECKSUM_BYTE_EN to append a third byte,
// result[15:8] ^ result[7:0], to every frame.

module uart_tx_result_ctrl #(
    parameter int WAIT_FOR_REGISTER_DELAY = 100,
    parameter int BUSY_TIMEOUT            = 1000,
    parameter bit LSB_FIRST               = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic [15:0] result,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [3:0]  LED
);

    // The state values double as the debug LED encoding.
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_HOLD    = 4'd1,
        S_START   = 4'd2,
        S_WAIT_HI = 4'd3,
        S_WAIT_LO = 4'd4,
        S_FINISH  = 4'd5
    } state_t;

`ifdef UART_TX_CHECKSUM_BYTE_EN
    localparam logic [1:0] LAST_IDX = 2'd2;
`else
    localparam logic [1:0] LAST_IDX = 2'd1;
`endif

    localparam int HOLD_W = $clog2(WAIT_FOR_REGISTER_DELAY + 2);
    localparam int TO_W   = $clog2(BUSY_TIMEOUT + 2);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(WAIT_FOR_REGISTER_DELAY);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(BUSY_TIMEOUT - 1);

    state_t            state;
    logic [15:0]       latched;
    logic [1:0]        byte_idx;
    logic [HOLD_W-1:0] hold_timer;
    logic [TO_W-1:0]   to_timer;

    // Byte sent at a given position of the frame.
    function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic [1:0] idx);
        logic [7:0] first_byte;
        logic [7:0] second_byte;
        first_byte  = LSB_FIRST ? word[7:0]  : word[15:8];
        second_byte = LSB_FIRST ? word[15:8] : word[7:0];
        case (idx)
            2'd0:    byte_sel = first_byte;
`ifdef UART_TX_CHECKSUM_BYTE_EN
            2'd2:    byte_sel = word[15:8] ^ word[7:0];
`endif
            default: byte_sel = second_byte;
        endcase
    endfunction

    assign LED = state;

    // Frame sequencer: hold byte, pulse start, follow the busy handshake, repeat.
    always_ff @(posedge clk) begin
        // NOTE: all state and outputs use non-blocking assignments so every
        // branch reads the values from before this edge.
        if (reset) begin
            state       <= S_IDLE;
            tx_start    <= 1'b0;
            tx_data     <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            latched     <= 16'd0;
            byte_idx    <= 2'd0;
            hold_timer  <= '0;
            to_timer    <= '0;
        end else begin
            // NOTE: pulse outputs default low here; only the transition that
            // needs them raises them for a single cycle.
            tx_start <= 1'b0;
            done     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        latched     <= result;
                        timeout_err <= 1'b0;
                        byte_idx    <= 2'd0;
                        tx_data     <= byte_sel(result, 2'd0);
                        hold_timer  <= '0;
                        busy        <= 1'b1;
                        state       <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (hold_timer >= HOLD_MAX) begin
                        hold_timer <= '0;
                        tx_start   <= 1'b1;
                        state      <= S_START;
                    end else begin
                        hold_timer <= hold_timer + 1'b1;
                    end
                end

                S_START: begin
                    to_timer <= '0;
                    state    <= S_WAIT_HI;
                end

                S_WAIT_HI: begin
                    if (tx_busy) begin
                        to_timer <= '0;
                        state    <= S_WAIT_LO;
                    end else if (to_timer == TO_LAST) begin
                        // The core never took the byte: abandon the rest of the frame.
                        to_timer    <= '0;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_FINISH;
                    end else begin
                        to_timer <= to_timer + 1'b1;
                    end
                end

                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (byte_idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                            tx_data  <= byte_sel(latched, byte_idx + 2'd1);
                            state    <= S_HOLD;
                        end
                    end
                end

                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_result_ctrl.sv
// tb_uart_tx_result_ctrl
// Two controller instances (LSB-first and MSB-first) each driven by a simple
// UART TX core model. Frames are compared against a byte-order model built
// from the result word. Honours UART_TX_CHECKSUM_BYTE_EN.

module tb_uart_tx_result_ctrl;

    localparam int DELAY = 100;
    localparam int TMO   = 1000;
`ifdef UART_TX_CHECKSUM_BYTE_EN
    localparam int NBYTES = 3;
`else
    localparam int NBYTES = 2;
`endif

    typedef struct {
        logic [7:0] data;
        int         gap;
        int         cyc;
    } start_rec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic        trig     [2];
    logic [15:0] res      [2];
    logic        tx_busy  [2];
    logic        tx_start [2];
    logic [7:0]  tx_data  [2];
    logic        busy     [2];
    logic        done     [2];
    logic        terr     [2];
    logic [3:0]  led      [2];

    // TX core model knobs, written by the main sequence only.
    bit never_busy [2];
    int rise_dly   [2];
    int busy_len   [2];

    start_rec_t recs0[$];
    start_rec_t recs1[$];
    int         dcyc0[$];
    int         dcyc1[$];

    int total  = 0;
    int passed = 0;
    int failed = 0;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        uart_tx_result_ctrl #(
            .WAIT_FOR_REGISTER_DELAY(DELAY),
            .BUSY_TIMEOUT(TMO),
            .LSB_FIRST(g == 0)
        ) dut (
            .clk(clk),
            .reset(reset),
            .trigger(trig[g]),
            .result(res[g]),
            .tx_busy(tx_busy[g]),
            .tx_start(tx_start[g]),
            .tx_data(tx_data[g]),
            .busy(busy[g]),
            .done(done[g]),
            .timeout_err(terr[g]),
            .LED(led[g])
        );

        // TX core model: after a start pulse, raise busy rise_dly cycles later
        // and keep it high for busy_len cycles.
        initial begin
            tx_busy[g] = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                if (tx_start[g] === 1'b1 && !never_busy[g]) begin
                    if (rise_dly[g] > 0) begin
                        repeat (rise_dly[g]) @(posedge clk);
                        #1;
                    end
                    tx_busy[g] = 1'b1;
                    repeat (busy_len[g]) @(posedge clk);
                    #1;
                    tx_busy[g] = 1'b0;
                end
            end
        end

        // Monitor: log every start pulse (byte, distance from HOLD entry) and done pulse.
        initial begin
            int         hold_entry;
            logic [3:0] prev_led;
            start_rec_t rec;
            hold_entry = 0;
            prev_led   = 4'd0;
            forever begin
                @(negedge clk);
                if (led[g] == 4'd1 && prev_led != 4'd1) hold_entry = cycle;
                prev_led = led[g];
                if (tx_start[g] === 1'b1) begin
                    rec.data = tx_data[g];
                    rec.gap  = cycle - hold_entry;
                    rec.cyc  = cycle;
                    if (g == 0) recs0.push_back(rec);
                    else        recs1.push_back(rec);
                end
                if (done[g] === 1'b1) begin
                    if (g == 0) dcyc0.push_back(cycle);
                    else        dcyc1.push_back(cycle);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: wire order of the frame bytes, derived from the result word.
    function automatic logic [7:0] model_byte(input logic [15:0] r, input bit lsb, input int i);
        logic [7:0] q[$];
        q = {};
        q.push_back(r[7:0]);
        q.push_back(r[15:8]);
        if (!lsb) q.reverse();
`ifdef UART_TX_CHECKSUM_BYTE_EN
        q.push_back(r[15:8] ^ r[7:0]);
`endif
        return q[i];
    endfunction

    function automatic int n_starts(input int g);
        return (g == 0) ? recs0.size() : recs1.size();
    endfunction

    function automatic int n_dones(input int g);
        return (g == 0) ? dcyc0.size() : dcyc1.size();
    endfunction

    function automatic start_rec_t get_rec(input int g, input int i);
        return (g == 0) ? recs0[i] : recs1[i];
    endfunction

    function automatic int get_dcyc(input int g, input int i);
        return (g == 0) ? dcyc0[i] : dcyc1[i];
    endfunction

    task automatic wait_led(input int g, input logic [3:0] v, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = (led[g] == v);
        end
    endtask

    task automatic pulse_trigger(input int g, input logic [15:0] r);
        @(posedge clk);
        #1;
        res[g]  = r;
        trig[g] = 1'b1;
        @(posedge clk);
        #1;
        trig[g] = 1'b0;
    endtask

    // One full frame on instance g, checked against the model.
    task automatic run_frame(input int g, input logic [15:0] r, input bit to_mode,
                             input bit extra_trig, input string tag);
        int         s0, d0, ns, nexp, dt;
        bit         ok;
        start_rec_t rec;
        s0 = n_starts(g);
        d0 = n_dones(g);
        never_busy[g] = to_mode;
        pulse_trigger(g, r);
        res[g] = 16'($urandom);
        check($sformatf("%s_busy_up", tag), busy[g], 1'b1);
        check($sformatf("%s_terr_clr", tag), terr[g], 1'b0);
        if (extra_trig) begin
            wait_led(g, 4'd4, 400, ok);
            check($sformatf("%s_reach_wait_lo", tag), ok, 1'b1);
            pulse_trigger(g, 16'hFFFF);
        end
        ok = 1'b0;
        for (int i = 0; i < 6000 && !ok; i++) begin
            @(negedge clk);
            ok = (n_dones(g) > d0);
        end
        check($sformatf("%s_done_seen", tag), ok, 1'b1);
        repeat (30) @(negedge clk);
        check($sformatf("%s_busy_low", tag), busy[g], 1'b0);
        check($sformatf("%s_led_idle", tag), led[g], 4'd0);
        check($sformatf("%s_done_count", tag), n_dones(g) - d0, 1);
        nexp = to_mode ? 1 : NBYTES;
        ns   = n_starts(g) - s0;
        check($sformatf("%s_start_count", tag), ns, nexp);
        for (int i = 0; i < nexp && i < ns; i++) begin
            rec = get_rec(g, s0 + i);
            check($sformatf("%s_byte%0d", tag, i), rec.data, model_byte(r, g == 0, i));
            check($sformatf("%s_gap%0d", tag, i), rec.gap >= DELAY, 1'b1);
        end
        check($sformatf("%s_terr", tag), terr[g], to_mode);
        if (to_mode && ns > 0 && n_dones(g) > d0) begin
            dt = get_dcyc(g, d0) - get_rec(g, s0).cyc;
            check($sformatf("%s_tmo_len(%0d)", tag, dt), dt >= TMO + 1 && dt <= TMO + 2, 1'b1);
        end
        never_busy[g] = 1'b0;
    endtask

    initial begin
        int         s0;
        bit         ok;
        logic [15:0] r;
        reset = 1'b1;
        for (int g = 0; g < 2; g++) begin
            trig[g]       = 1'b0;
            res[g]        = 16'd0;
            never_busy[g] = 1'b0;
            rise_dly[g]   = 2;
            busy_len[g]   = 50;
        end

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy[0], 1'b0);
        check("rst_tx_start", tx_start[0], 1'b0);
        check("rst_tx_data", tx_data[0], 8'd0);
        check("rst_done", done[0], 1'b0);
        check("rst_terr", terr[0], 1'b0);
        check("rst_led", led[0], 4'd0);
        reset = 1'b0;

        // Directed frames
        run_frame(0, 16'hA53C, 1'b0, 1'b0, "basic");
        run_frame(1, 16'h1234, 1'b0, 1'b0, "order");
        run_frame(0, 16'hA53C, 1'b0, 1'b1, "ignore");
        run_frame(0, 16'($urandom), 1'b1, 1'b0, "timeout");
        run_frame(0, 16'h00FF, 1'b0, 1'b0, "after_tmo");

        // Randomised frames and TX core timing, including busy already high
        // when the controller starts waiting for it.
        for (int i = 0; i < 6; i++) begin
            rise_dly[i % 2] = int'($urandom_range(0, 4));
            busy_len[i % 2] = int'($urandom_range(2, 40));
            r = 16'($urandom);
            run_frame(i % 2, r, 1'b0, 1'b0, $sformatf("rand%0d", i));
        end

        // Reset while holding the second byte
        rise_dly[0] = 2;
        busy_len[0] = 50;
        s0 = n_starts(0);
        pulse_trigger(0, 16'hA53C);
        ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            ok = (n_starts(0) == s0 + 1) && (led[0] == 4'd1);
        end
        check("mid_rst_reach_hold1", ok, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", busy[0], 1'b0);
        check("mid_rst_tx_start", tx_start[0], 1'b0);
        check("mid_rst_tx_data", tx_data[0], 8'd0);
        check("mid_rst_led", led[0], 4'd0);
        check("mid_rst_done", done[0], 1'b0);
        reset = 1'b0;
        repeat (400) @(negedge clk);
        check("mid_rst_no_start", n_starts(0) - s0, 1);
        check("mid_rst_idle", led[0], 4'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
